// File: rtl/mem_wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_pkg
//   Shared definitions for the MEM/WB stage and its writeback source mux.
//   - WB_SEL_* : writeback source encodings (ALU / memory / PC+2; 2'b11
//                is treated as ALU)
//   - state_t  : MEM/WB handshake FSM states
//   - DEFAULT_TIMEOUT / DEFAULT_CNT_W : default wait limit and counter width
// ---------------------------------------------------------------------------
package mem_wb_stage_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // The counter must hold TIMEOUT-1, so 2**DEFAULT_CNT_W > DEFAULT_TIMEOUT.
    localparam int DEFAULT_TIMEOUT = 64;
    localparam int DEFAULT_CNT_W   = 7;

endpackage

// File: rtl/wb_mux4_16.sv
// ---------------------------------------------------------------------------
// wb_mux4_16
//   16-bit 4:1 writeback source select. Shared with the forwarding unit,
//   so all four data inputs are exposed even though the writeback path
//   ties d3 to the ALU result.
//   Ports:
//     sel  in  2   source select (WB_SEL_* encodings)
//     d0   in  16  selected by WB_SEL_ALU
//     d1   in  16  selected by WB_SEL_MEM
//     d2   in  16  selected by WB_SEL_PC
//     d3   in  16  selected by 2'b11
//     y    out 16  selected data
// ---------------------------------------------------------------------------
module wb_mux4_16
    import mem_wb_stage_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [15:0] d0,
    input  logic [15:0] d1,
    input  logic [15:0] d2,
    input  logic [15:0] d3,
    output logic [15:0] y
);

    always_comb begin
        y = d3;
        unique case (sel)
            WB_SEL_ALU: y = d0;
            WB_SEL_MEM: y = d1;
            WB_SEL_PC:  y = d2;
            default:    y = d3;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   Memory-to-writeback stage. Hides variable memory latency behind a small
//   IDLE/WAIT FSM, raising mem_busy to freeze fetch/decode/execute and the
//   EX/MEM register while an access is outstanding, and inserts bubbles
//   into writeback meanwhile. Produces the registered register-file write
//   bundle and a sticky error flag for memory errors and timeouts.
//
//   Parameters:
//     USE_CACHE  1 = Done/Stall handshake; 0 = single-cycle memory, every
//                access completes in its issue cycle (Done/Stall ignored)
//     TIMEOUT    max cycles spent in WAIT before a timeout error
//     CNT_W      wait counter width, 2**CNT_W > TIMEOUT
//
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     valid_in        EX/MEM holds a real instruction
//     ALU_result      ALU result / memory address
//     pc_plus2        link value
//     MemRead/MemWrite load / store
//     reg_write       instruction writes the register file
//     write_reg       destination register
//     wb_sel          writeback source select
//     halt_in         instruction is HALT
//     read_data_out   load data from memory
//     Done            access-complete pulse
//     Stall           memory cannot accept a request (never completes one)
//     mem_err         memory error, qualified by Done (or USE_CACHE=0)
//     mem_busy        freeze upstream (combinational)
//     wb_valid        bundle holds a retiring instruction
//     wb_en           register-file write enable
//     wb_reg, wb_data register-file write address / data
//     halt_out        HALT retiring (one-cycle pulse)
//     err_out         sticky error: memory error or timeout
// ---------------------------------------------------------------------------
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int USE_CACHE = 1,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [15:0] ALU_result,
    input  logic [15:0] pc_plus2,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        reg_write,
    input  logic [2:0]  write_reg,
    input  logic [1:0]  wb_sel,
    input  logic        halt_in,
    input  logic [15:0] read_data_out,
    input  logic        Done,
    input  logic        Stall,
    input  logic        mem_err,
    output logic        mem_busy,
    output logic        wb_valid,
    output logic        wb_en,
    output logic [2:0]  wb_reg,
    output logic [15:0] wb_data,
    output logic        halt_out,
    output logic        err_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic        access;
    logic        done_eff;
    logic        retire;      // capture the bundle as a retiring instruction
    logic        kill_wen;    // retire but suppress the register write
    logic        set_err;
    logic        busy;
    logic [15:0] sel_data;

    // Stall is informational only: an access completes on Done alone,
    // whether or not Stall is also high.
    logic unused_stall;
    assign unused_stall = Stall;

    assign access   = valid_in & (MemRead | MemWrite);
    assign done_eff = (USE_CACHE == 0) ? 1'b1 : Done;

    wb_mux4_16 u_wb_mux (
        .sel (wb_sel),
        .d0  (ALU_result),
        .d1  (read_data_out),
        .d2  (pc_plus2),
        .d3  (ALU_result),
        .y   (sel_data)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retire     = 1'b0;
        kill_wen   = 1'b0;
        set_err    = 1'b0;
        busy       = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (valid_in) begin
                    if (!access || done_eff) begin
                        retire = 1'b1;
                        if (access && mem_err) begin
                            kill_wen = 1'b1;
                            set_err  = 1'b1;
                        end
                    end else begin
                        // Miss: park in WAIT, emit a bubble this edge.
                        state_next = ST_WAIT;
                        cnt_next   = '0;
                        busy       = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                if (Done) begin
                    retire     = 1'b1;
                    state_next = ST_IDLE;
                    if (mem_err) begin
                        kill_wen = 1'b1;
                        set_err  = 1'b1;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    // Timeout retires the instruction at this edge, so the
                    // upstream freeze is released in the same cycle, exactly
                    // like a completion; otherwise the stuck access would be
                    // re-issued from the held EX/MEM register.
                    retire     = 1'b1;
                    kill_wen   = 1'b1;
                    set_err    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    busy     = 1'b1;
                    cnt_next = (cnt_reg == CNT_LAST) ? cnt_reg : cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Reset forces the freeze off immediately, even with an access pending
    // on the EX/MEM inputs.
    assign mem_busy = busy & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            wb_valid  <= 1'b0;
            wb_en     <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
            halt_out  <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            wb_valid  <= retire;
            wb_en     <= retire & reg_write & ~kill_wen;
            halt_out  <= retire & halt_in;
            // Address/data hold their last value across bubbles.
            if (retire) begin
                wb_reg  <= write_reg;
                wb_data <= sel_data;
            end
            if (set_err) begin
                err_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
`timescale 1ns/1ps
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic [15:0] ALU_result = '0;
    logic [15:0] pc_plus2 = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic        reg_write = 1'b0;
    logic [2:0]  write_reg = '0;
    logic [1:0]  wb_sel = '0;
    logic        halt_in = 1'b0;
    logic [15:0] read_data_out = '0;
    logic        Done = 1'b0;
    logic        Stall = 1'b0;
    logic        mem_err = 1'b0;

    // cache-handshake instance (short timeout)
    logic        mem_busy, wb_valid, wb_en, halt_out, err_out;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;

    // single-cycle memory instance
    logic        nc_mem_busy, nc_wb_valid, nc_wb_en, nc_halt_out, nc_err_out;
    logic [2:0]  nc_wb_reg;
    logic [15:0] nc_wb_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.USE_CACHE(1), .TIMEOUT(8), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ALU_result(ALU_result),
        .pc_plus2(pc_plus2), .MemRead(MemRead), .MemWrite(MemWrite),
        .reg_write(reg_write), .write_reg(write_reg), .wb_sel(wb_sel),
        .halt_in(halt_in), .read_data_out(read_data_out), .Done(Done),
        .Stall(Stall), .mem_err(mem_err), .mem_busy(mem_busy),
        .wb_valid(wb_valid), .wb_en(wb_en), .wb_reg(wb_reg),
        .wb_data(wb_data), .halt_out(halt_out), .err_out(err_out)
    );

    mem_wb_stage #(.USE_CACHE(0), .TIMEOUT(8), .CNT_W(4)) u_dut_nc (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ALU_result(ALU_result),
        .pc_plus2(pc_plus2), .MemRead(MemRead), .MemWrite(MemWrite),
        .reg_write(reg_write), .write_reg(write_reg), .wb_sel(wb_sel),
        .halt_in(halt_in), .read_data_out(read_data_out), .Done(Done),
        .Stall(Stall), .mem_err(mem_err), .mem_busy(nc_mem_busy),
        .wb_valid(nc_wb_valid), .wb_en(nc_wb_en), .wb_reg(nc_wb_reg),
        .wb_data(nc_wb_data), .halt_out(nc_halt_out), .err_out(nc_err_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic set_instr(input logic v, input logic mr, input logic mw, input logic rw,
                             input logic hlt, input logic [2:0] wr, input logic [1:0] sel,
                             input logic [15:0] alu, input logic [15:0] pc);
        valid_in   = v;
        MemRead    = mr;
        MemWrite   = mw;
        reg_write  = rw;
        halt_in    = hlt;
        write_reg  = wr;
        wb_sel     = sel;
        ALU_result = alu;
        pc_plus2   = pc;
    endtask

    task automatic set_mem(input logic dn, input logic st, input logic er, input logic [15:0] rd);
        Done          = dn;
        Stall         = st;
        mem_err       = er;
        read_data_out = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 16'h0000, 16'h0000);
        set_mem(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        #1 rst = 1'b1;
        #2;
        check("rst_mem_busy", {31'd0, mem_busy}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_en",    {31'd0, wb_en},    32'd0);
        check("rst_wb_reg",   {29'd0, wb_reg},   32'd0);
        check("rst_wb_data",  {16'd0, wb_data},  32'd0);
        check("rst_halt_out", {31'd0, halt_out}, 32'd0);
        check("rst_err_out",  {31'd0, err_out},  32'd0);

        // ---- single-cycle ALU op ----
        @(negedge clk);
        rst = 1'b0;
        set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 2'b00, 16'h1234, 16'h0000);
        #1 check("alu_busy", {31'd0, mem_busy}, 32'd0);
        tick();
        check("alu_wb_en",   {31'd0, wb_en},   32'd1);
        check("alu_wb_reg",  {29'd0, wb_reg},  32'd3);
        check("alu_wb_data", {16'd0, wb_data}, 32'h1234);
        @(negedge clk);
        clear_inputs();
        tick();
        check("bubble_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("bubble_wb_en",    {31'd0, wb_en},    32'd0);

        // ---- cache load, 3-cycle miss, Stall high throughout ----
        @(negedge clk);
        set_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 2'b01, 16'h0100, 16'h0000);
        set_mem(1'b0, 1'b1, 1'b0, 16'h0000);
        #1 check("miss_busy_c1", {31'd0, mem_busy}, 32'd1);
        tick();
        check("miss_wb_en_c1", {31'd0, wb_en}, 32'd0);
        for (int i = 2; i <= 3; i++) begin
            @(negedge clk);
            #1 check($sformatf("miss_busy_c%0d", i), {31'd0, mem_busy}, 32'd1);
            tick();
            check($sformatf("miss_wb_en_c%0d", i), {31'd0, wb_en}, 32'd0);
        end
        @(negedge clk);
        set_mem(1'b1, 1'b1, 1'b0, 16'hBEEF);
        #1 check("miss_busy_c4", {31'd0, mem_busy}, 32'd0);
        tick();
        check("miss_wb_data",  {16'd0, wb_data},  32'hBEEF);
        check("miss_wb_reg",   {29'd0, wb_reg},   32'd5);
        check("miss_wb_en",    {31'd0, wb_en},    32'd1);
        check("miss_wb_valid", {31'd0, wb_valid}, 32'd1);

        // ---- cache hit ----
        @(negedge clk);
        set_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 2'b01, 16'h0104, 16'h0000);
        set_mem(1'b1, 1'b0, 1'b0, 16'hCAFE);
        #1 check("hit_busy", {31'd0, mem_busy}, 32'd0);
        tick();
        check("hit_wb_data", {16'd0, wb_data}, 32'hCAFE);
        check("hit_wb_reg",  {29'd0, wb_reg},  32'd2);
        check("hit_wb_en",   {31'd0, wb_en},   32'd1);

        // ---- timeout on a store (TIMEOUT=8) ----
        @(negedge clk);
        set_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 16'h0200, 16'h0000);
        set_mem(1'b0, 1'b0, 1'b0, 16'h0000);
        #1 check("to_busy_issue", {31'd0, mem_busy}, 32'd1);
        tick();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            #1 check($sformatf("to_busy_w%0d", i), {31'd0, mem_busy}, 32'd1);
            tick();
            check($sformatf("to_err_w%0d", i), {31'd0, err_out}, 32'd0);
        end
        tick();
        check("to_err_set",  {31'd0, err_out},  32'd1);
        check("to_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("to_wb_en",    {31'd0, wb_en},    32'd0);
        @(negedge clk);
        clear_inputs();
        #1 check("to_busy_drop", {31'd0, mem_busy}, 32'd0);
        tick();
        check("to_err_sticky", {31'd0, err_out}, 32'd1);

        // ---- reset two cycles into WAIT ----
        @(negedge clk);
        set_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 2'b01, 16'h0300, 16'h0000);
        tick();
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rw_mem_busy", {31'd0, mem_busy}, 32'd0);
        check("rw_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rw_wb_data",  {16'd0, wb_data},  32'd0);
        check("rw_err_out",  {31'd0, err_out},  32'd0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        set_mem(1'b1, 1'b0, 1'b0, 16'h1111);
        tick();
        check("rw_no_retire_1", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        set_mem(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        check("rw_no_retire_2", {31'd0, wb_valid}, 32'd0);

        // ---- HALT pulse ----
        @(negedge clk);
        set_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00, 16'h0000, 16'h0000);
        tick();
        check("halt_pulse", {31'd0, halt_out}, 32'd1);
        check("halt_wb_en", {31'd0, wb_en},    32'd0);
        @(negedge clk);
        clear_inputs();
        tick();
        check("halt_clear", {31'd0, halt_out}, 32'd0);

        // ---- memory error on a hit ----
        @(negedge clk);
        set_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 2'b01, 16'h0400, 16'h0000);
        set_mem(1'b1, 1'b0, 1'b1, 16'h7777);
        tick();
        check("merr_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("merr_wb_en",    {31'd0, wb_en},    32'd0);
        check("merr_err_out",  {31'd0, err_out},  32'd1);
        @(negedge clk);
        clear_inputs();
        tick();
        check("merr_sticky", {31'd0, err_out}, 32'd1);

        // ---- USE_CACHE=0: back-to-back load then JAL ----
        @(negedge clk);
        set_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 2'b01, 16'h0300, 16'h0000);
        set_mem(1'b0, 1'b1, 1'b0, 16'h5A5A);
        #1 check("nc_busy", {31'd0, nc_mem_busy}, 32'd0);
        tick();
        check("nc_ld_data", {16'd0, nc_wb_data}, 32'h5A5A);
        check("nc_ld_reg",  {29'd0, nc_wb_reg},  32'd1);
        check("nc_ld_en",   {31'd0, nc_wb_en},   32'd1);
        @(negedge clk);
        set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 2'b10, 16'h9999, 16'h0042);
        set_mem(1'b1, 1'b1, 1'b0, 16'hDEAD);
        tick();
        check("nc_jal_data", {16'd0, nc_wb_data}, 32'h0042);
        check("nc_jal_reg",  {29'd0, nc_wb_reg},  32'd7);
        check("nc_jal_en",   {31'd0, nc_wb_en},   32'd1);
        @(negedge clk);
        clear_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumes the memory stage outputs (load data, Done, Stall, err) plus EX/MEM control and produces the registered writeback bundle for the register file.
- Hides variable memory latency: holds the in-flight access in a small FSM and asserts mem_busy so that fetch, decode and execute freeze.
- Inserts bubbles into writeback while waiting.
- Performs the writeback source select and flags timeouts and memory errors.

Parameters:
- USE_CACHE, 1: 1 = Done/Stall handshake from the cache; 0 = aligned single-cycle memory, where every access completes in its issue cycle and Done/Stall are ignored.
- TIMEOUT, 64: maximum cycles in WAIT before a timeout error.
- CNT_W, 7: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- valid_in  in  1  EX/MEM holds a real instruction.
- ALU_result  in  16  ALU result; also the memory address.
- pc_plus2  in  16  PC+2, used for link writes.
- MemRead  in  1  instruction is a load.
- MemWrite  in  1  instruction is a store.
- reg_write  in  1  instruction writes the register file.
- write_reg  in  3  destination register.
- wb_sel  in  2  writeback source: 00 = ALU, 01 = memory, 10 = PC+2, 11 = ALU.
- halt_in  in  1  instruction is HALT.
- read_data_out  in  16  load data from the memory stage.
- Done  in  1  one-cycle pulse: access complete, read_data_out valid.
- Stall  in  1  memory busy, cannot accept a new request.
- mem_err  in  1  memory error, qualified by Done or USE_CACHE=0.
- mem_busy  out  1  freeze upstream stages, including the EX/MEM register.
- wb_valid  out  1  writeback bundle holds a retiring instruction.
- wb_en  out  1  register-file write enable (wb_valid & reg_write).
- wb_reg  out  3  register-file write address.
- wb_data  out  16  register-file write data.
- halt_out  out  1  HALT retiring; drives createdump.
- err_out  out  1  sticky error: memory error or timeout.

Behaviour:
- Reset (asynchronous, immediate): FSM = IDLE, counter = 0; wb_valid, wb_en, wb_reg, wb_data, halt_out, err_out = 0; mem_busy = 0.
- An access is valid_in & (MemRead | MemWrite).
- FSM states: IDLE, WAIT.
- IDLE, non-access valid instruction: capture the bundle next edge. Latency is 1 cycle.
- IDLE, access with Done=1 in the same cycle (or USE_CACHE=0): capture next edge. For a load, wb_data = read_data_out sampled that cycle.
- IDLE, access with Done=0 (USE_CACHE=1):
  - Go to WAIT and clear the counter.
  - Register the bundle as a bubble: wb_valid = 0, wb_en = 0.
  - mem_busy is combinational: 1 in this cycle and in every WAIT cycle until Done.
- WAIT: EX/MEM inputs are held stable by upstream because mem_busy=1. The counter increments each cycle.
  - Done=1: capture the bundle (load data from read_data_out), go to IDLE, mem_busy=0 that same cycle.
  - Counter reaches TIMEOUT-1 with no Done: set err_out, retire the instruction with wb_en forced to 0, go to IDLE.
- Stall alone never completes an access. Stall=1 while Done=1 counts as complete.
- A store retires with wb_en=0 unless reg_write=1; reg_write=1 on a store is illegal, but the value written is then selected by wb_sel.
- mem_err with Done, or with USE_CACHE=0: err_out sets (sticky until reset). The instruction still retires with wb_en=0.
- valid_in=0 in IDLE: bubble; no access is started even if MemRead or MemWrite is set.
- halt_out: registered, equal to valid & halt_in of the captured bundle. It pulses for one cycle per HALT.
- Reset in WAIT: return to IDLE immediately. The pending access is abandoned and no writeback occurs.
- Widths: all data is 16 bits with no arithmetic. The counter saturates at TIMEOUT-1 and never wraps.

Decomposition:
- Shared package:
  - WB_SEL_ALU / WB_SEL_MEM / WB_SEL_PC encodings.
  - FSM state encodings IDLE=1'b0, WAIT=1'b1.
  - Default TIMEOUT.
- One natural sub-module: wb_mux4_16, the 16-bit 4:1 writeback source select, reused by the forwarding unit.
- FSM, counter and output registers live in mem_wb_stage.

Test Plan:
- Single-cycle ALU op: valid_in=1, reg_write=1, write_reg=3, wb_sel=00, ALU_result=16'h1234 -> next cycle wb_en=1, wb_reg=3, wb_data=16'h1234, mem_busy=0 throughout.
- Cache load, 3-cycle miss: MemRead=1, wb_sel=01; Done asserted on the 4th cycle with read_data_out=16'hBEEF -> mem_busy=1 for cycles 1-3 and 0 in cycle 4; wb_en=0 during the wait; next edge wb_data=16'hBEEF, wb_reg matches write_reg.
- Cache hit: MemRead with Done=1 in the issue cycle -> no WAIT, mem_busy never asserted, data written 1 cycle later.
- Timeout: TIMEOUT=8, store issued, Done held 0 -> after 8 cycles err_out=1 (sticky), FSM back to IDLE, wb_en=0, mem_busy drops.
- USE_CACHE=0: back-to-back load then JAL (wb_sel=10, pc_plus2=16'h0042) -> two consecutive retirements with wb_data = load data, then 16'h0042; Done/Stall stimulus ignored.
- Reset mid-WAIT, plus HALT: assert rst two cycles into WAIT -> all outputs 0 at once, no retirement after release. Then HALT (non-access) -> halt_out pulses for exactly 1 cycle.
